// File: rtl/fft_scan_pkg.sv
// Shared types and widths for the FFT peak-scan controller and its datapath.
package fft_scan_pkg;

    localparam int BIN_W         = 8;
    localparam int RES_W         = 16;
    localparam int DEF_N_BINS    = 128;
    localparam int DEF_FIRST_BIN = 1;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        SCAN,
        REPORT
    } state_t;

endpackage

// File: rtl/fft_peak_track.sv
// Peak-tracking datapath: aligns each bin index with its Result, takes a saturating
// magnitude and keeps the running maximum (lowest bin wins ties).
module fft_peak_track
    import fft_scan_pkg::*;
#(
    parameter int FIRST_BIN = DEF_FIRST_BIN,
    parameter int READ_LAT  = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_clear,
    input  logic                    i_vld,
    input  logic [BIN_W-1:0]        i_bin,
    input  logic signed [RES_W-1:0] i_result,
    output logic                    o_pending,
    output logic [BIN_W-1:0]        o_max_bin,
    output logic [RES_W-1:0]        o_max_mag
);

    function automatic logic [RES_W-1:0] sat_abs(input logic signed [RES_W-1:0] x);
        logic signed [RES_W-1:0] neg;
        if (x == {1'b1, {(RES_W-1){1'b0}}}) begin
            return {1'b0, {(RES_W-1){1'b1}}};
        end
        neg = -x;
        return x[RES_W-1] ? $unsigned(neg) : $unsigned(x);
    endfunction

    logic                 w_cmp_vld;
    logic [BIN_W-1:0]     w_cmp_bin;
    logic [RES_W-1:0]     w_mag;
    logic [BIN_W-1:0]     r_max_bin;
    logic [RES_W-1:0]     r_max_mag;

    // Stage p0..pN: address valid/bin delayed to line up with the engine's read latency
    generate
        if (READ_LAT == 0) begin : g_direct
            assign w_cmp_vld = i_vld;
            assign w_cmp_bin = i_bin;
            assign o_pending = 1'b0;
        end else begin : g_pipe
            logic [READ_LAT-1:0]            r_vld_p;
            logic [READ_LAT-1:0][BIN_W-1:0] r_bin_p;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_vld_p <= '0;
                end else begin
                    r_vld_p <= READ_LAT'({r_vld_p, i_vld});
                end
            end

            always_ff @(posedge i_clk) begin
                r_bin_p <= (READ_LAT*BIN_W)'({r_bin_p, i_bin});
            end

            assign w_cmp_vld = r_vld_p[READ_LAT-1];
            assign w_cmp_bin = r_bin_p[READ_LAT-1];
            assign o_pending = |r_vld_p;
        end
    endgenerate

    assign w_mag = sat_abs(i_result);

    // Compare stage: cleared on scan entry, so no reset is needed on the max registers
    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            r_max_mag <= '0;
            r_max_bin <= BIN_W'(FIRST_BIN);
        end else if (w_cmp_vld && (w_mag > r_max_mag)) begin
            r_max_mag <= w_mag;
            r_max_bin <= w_cmp_bin;
        end
    end

    assign o_max_bin = r_max_bin;
    assign o_max_mag = r_max_mag;

endmodule

// File: rtl/fft_peak_scan.sv
// Host-side FFT controller: requests a transform, waits for Done, sweeps Inspect
// across the spectrum and reports the strongest bin once per frame.
module fft_peak_scan
    import fft_scan_pkg::*;
#(
    parameter int N_BINS    = DEF_N_BINS,
    parameter int FIRST_BIN = DEF_FIRST_BIN,
    parameter int READ_LAT  = 1
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    Enable,
    input  logic                    Ready,
    input  logic                    Done,
    output logic                    Start,
    output logic [BIN_W-1:0]        Inspect,
    input  logic signed [RES_W-1:0] Result,
    output logic [BIN_W-1:0]        PeakBin,
    output logic [RES_W-1:0]        PeakMag,
    output logic                    PeakValid,
    output logic                    Busy
);

    localparam logic [BIN_W-1:0] FIRST_ADDR = BIN_W'(FIRST_BIN);
    localparam logic [BIN_W-1:0] LAST_ADDR  = BIN_W'(N_BINS - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [BIN_W-1:0]     r_addr;
    logic                 r_addr_vld;
    logic                 r_start;
    logic                 r_busy;
    logic                 r_peak_vld;
    logic [BIN_W-1:0]     r_peak_bin;
    logic [RES_W-1:0]     r_peak_mag;
    logic                 w_clear;
    logic                 w_pending;
    logic [BIN_W-1:0]     w_max_bin;
    logic [RES_W-1:0]     w_max_mag;

    assign w_clear = (r_state == WAIT) && Done;

    // SCAN ends only once the last address has left the read-latency pipe
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (Enable && Ready)            w_state_nxt = REQ;
            REQ:     if (!Ready)                     w_state_nxt = WAIT;
            WAIT:    if (Done)                       w_state_nxt = SCAN;
            SCAN:    if (!r_addr_vld && !w_pending)  w_state_nxt = REPORT;
            REPORT:                                  w_state_nxt = IDLE;
            default:                                 w_state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so each one matches the state it labels
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state    <= IDLE;
            r_start    <= 1'b0;
            r_busy     <= 1'b0;
            r_peak_vld <= 1'b0;
            r_addr     <= '0;
            r_addr_vld <= 1'b0;
            r_peak_bin <= '0;
            r_peak_mag <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_start    <= (w_state_nxt == REQ);
            r_busy     <= (w_state_nxt != IDLE);
            r_peak_vld <= (w_state_nxt == REPORT);
            if (w_clear) begin
                r_addr     <= FIRST_ADDR;
                r_addr_vld <= 1'b1;
            end else if ((r_state == SCAN) && r_addr_vld) begin
                if (r_addr == LAST_ADDR) begin
                    r_addr_vld <= 1'b0;
                end else begin
                    r_addr <= r_addr + BIN_W'(1);
                end
            end else if (w_state_nxt == REPORT) begin
                r_addr <= '0;
            end
            if (w_state_nxt == REPORT) begin
                r_peak_bin <= w_max_bin;
                r_peak_mag <= w_max_mag;
            end
        end
    end

    fft_peak_track #(
        .FIRST_BIN (FIRST_BIN),
        .READ_LAT  (READ_LAT)
    ) u_track (
        .i_clk     (Clk),
        .i_rst_n   (Reset_n),
        .i_clear   (w_clear),
        .i_vld     (r_addr_vld),
        .i_bin     (r_addr),
        .i_result  (Result),
        .o_pending (w_pending),
        .o_max_bin (w_max_bin),
        .o_max_mag (w_max_mag)
    );

    assign Start     = r_start;
    assign Inspect   = r_addr;
    assign PeakBin   = r_peak_bin;
    assign PeakMag   = r_peak_mag;
    assign PeakValid = r_peak_vld;
    assign Busy      = r_busy;

endmodule

// File: doc/fft_peak_scan.md
# fft_peak_scan

Host-side controller for the FFT engine's start/ready/done and inspect/result interface. It requests a transform when the engine is ready, waits for completion, then sweeps the bin index across the spectrum. It reads each signed 16-bit result, tracks the bin with the largest saturated magnitude, and reports that bin and its magnitude once per frame to the display and tuning logic.

## Interface
Parameters:
- N_BINS, 128: number of bins scanned; exclusive upper index, 2..256.
- FIRST_BIN, 1: first bin scanned (1 skips DC); must be < N_BINS.
- READ_LAT, 1: cycles from an Inspect change to a valid Result, 0..3.

Ports:
- Clk  in  1  single clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Enable  in  1  level; while high, frames run back-to-back.
- Ready  in  1  engine idle and able to accept Start.
- Done  in  1  engine finished a transform; treated as an event, level or pulse.
- Start  out  1  transform request to the engine.
- Inspect  out  8  bin index presented to the engine.
- Result  in  16  signed bin value for the current Inspect.
- PeakBin  out  8  bin index of the last reported peak.
- PeakMag  out  16  unsigned magnitude of the last reported peak.
- PeakValid  out  1  one-cycle pulse when PeakBin/PeakMag update.
- Busy  out  1  high in every state except IDLE.

## Operation
- States:
  - IDLE: Enable && Ready → REQ.
  - REQ: Start=1, held until Ready is sampled low (accepted) → WAIT.
  - WAIT: Done sampled high → SCAN.
  - SCAN: ends after the last compare → REPORT.
  - REPORT: one cycle → IDLE.
- SCAN addressing: Inspect steps FIRST_BIN, FIRST_BIN+1, …, N_BINS-1, one per cycle, then holds. Each Result is sampled READ_LAT cycles after its address.
- Magnitude: Mag = |Result|, saturating, so -32768 → 32767 and the output stays 16-bit unsigned.
- Compare: the running max resets to 0 / bin FIRST_BIN on SCAN entry. Replace only on strictly greater, so ties keep the lowest bin. An all-zero spectrum reports bin FIRST_BIN, magnitude 0.
- REPORT: load PeakBin/PeakMag from the running max, PeakValid=1, Inspect returns to 0. PeakBin/PeakMag hold until the next REPORT.
- Enable low mid-frame: the current frame completes and reports, then the block stays in IDLE. Enable is sampled only in IDLE.
- Done high while in IDLE, REQ or SCAN: ignored.
- Ready dropping before Start is asserted: no request is issued; the block stays in IDLE.
- Reset_n low at any time: immediate return to IDLE with all outputs at reset values; any partial scan is discarded.

## Timing
- Reset values: Start 0, Inspect 0, PeakBin 0, PeakMag 0, PeakValid 0, Busy 0.
- Start rises the cycle after the edge where Enable && Ready is sampled in IDLE.
- Let E0 be the edge where Done is sampled high in WAIT, and K = N_BINS - FIRST_BIN:
  - Inspect = FIRST_BIN in the cycle after E0.
  - PeakValid is high in the cycle beginning at edge E0+K+READ_LAT+1 (defaults: E0+129).
- Back-to-back frames: the cycle after REPORT is IDLE. If Enable && Ready, Start rises one cycle later.
- No combinational path from any input to any output; every output is registered.

## Structure
- Package fft_scan_pkg holds:
  - state enum: IDLE, REQ, WAIT, SCAN, REPORT.
  - BIN_W = 8, RES_W = 16.
  - default N_BINS and FIRST_BIN.
- Sub-module fft_peak_track holds the datapath: a READ_LAT-deep valid/bin delay pipe, the saturating abs, and the running-max registers with clear/enable. The FSM and address counter stay in the top module.

## Test plan
- Engine model: Ready high, Done 40 cycles after accept; Result = 100 at bin 37, 0 elsewhere.
  - Start high until Ready falls; PeakValid once at E0+129; PeakBin=37, PeakMag=100.
- Result = -32768 at bin 5, +32767 at bin 90, small values elsewhere → PeakBin=5, PeakMag=32767 (tie resolves to the lower bin).
- All-zero spectrum, plus DC bin 0 = 5000 → PeakBin=1, PeakMag=0 (DC skipped).
- Enable held high for three frames, with a different peak bin each frame → three PeakValid pulses with matching bins. Enable dropped mid-third-frame → the third frame still reports, then Busy=0 and no fourth Start.
- Reset_n pulsed low at the 50th SCAN cycle → all outputs 0 at once. After release with Enable high, a fresh frame runs; the previous partial max does not leak into the new result.
- READ_LAT=3 build, peak at bin N_BINS-1 = 127 → PeakBin=127, PeakValid at E0+131.
